// File: rtl/sie_tx_pkg.sv
// Shared types and constants for the SIE transmit path.
// Used by the CRC append mux and its shift register.
package sie_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } state_t;

  localparam logic [1:0] SEL_IDLE    = 2'd0;
  localparam logic [1:0] SEL_PAYLOAD = 2'd1;
  localparam logic [1:0] SEL_CRC5    = 2'd2;
  localparam logic [1:0] SEL_CRC16   = 2'd3;

  localparam int CRC5_W_DEF  = 5;
  localparam int CRC16_W_DEF = 16;

endpackage

// File: rtl/crc_shift_reg.sv
// Holds the captured CRC and walks a down-counter across it.
// The counter stops at zero, so it never wraps.
module crc_shift_reg
  import sie_tx_pkg::*;
#(
  parameter int W         = CRC16_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 load,
  input  logic                 shift,
  input  logic [W-1:0]         load_val,
  input  logic [$clog2(W)-1:0] load_cnt,
  output logic                 bit_out,
  output logic                 last_bit
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  sr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] top_q;
  logic [CW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      top_q <= '0;
    end else if (!stall) begin
      if (load) begin
        sr_q  <= load_val;
        cnt_q <= load_cnt;
        top_q <= load_cnt;
      end else if (shift && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // top_q remembers the field width so LSB-first order works for both CRCs
  assign idx      = (MSB_FIRST != 0) ? cnt_q : (top_q - cnt_q);
  assign bit_out  = sr_q[idx];
  assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/crc_append_mux.sv
// Transmit payload/CRC mux: passes payload bits through, then appends the
// token CRC5 or data CRC16 bit by bit, freezing while the stuffer stalls.
//
// state   | meaning
// IDLE    | no packet; out_bit parks at IDLE_LEVEL
// PAYLOAD | echoing accepted payload beats
// CRC     | shifting out the captured CRC, payload not accepted
module crc_append_mux
  import sie_tx_pkg::*;
#(
  parameter int   CRC5_W     = CRC5_W_DEF,
  parameter int   CRC16_W    = CRC16_W_DEF,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               data_bit,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic               eop_token,
  input  logic               eop_data,
  input  logic [CRC5_W-1:0]  crc5_in,
  input  logic [CRC16_W-1:0] crc16_in,
  output logic               out_bit,
  output logic               out_valid,
  output logic [1:0]         out_sel,
  output logic               crc_done,
  output logic               err_pulse
);

  localparam int CW = $clog2(CRC16_W);

  state_t             state_q, state_d;
  logic               out_bit_d, out_valid_d, crc_done_d, err_d;
  logic [1:0]         out_sel_d, crc_sel_q, crc_sel_d;
  logic               load, shift, accept, crc_bit, last_bit;
  logic [CRC16_W-1:0] load_val;
  logic [CW-1:0]      load_cnt;

  assign data_ready = ~stall_in & (state_q != CRC);
  assign accept     = data_valid & data_ready;

  crc_shift_reg #(
    .W         (CRC16_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall_in),
    .load     (load),
    .shift    (shift),
    .load_val (load_val),
    .load_cnt (load_cnt),
    .bit_out  (crc_bit),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    out_bit_d   = out_bit;
    out_valid_d = 1'b0;
    out_sel_d   = out_sel;
    crc_sel_d   = crc_sel_q;
    crc_done_d  = 1'b0;
    err_d       = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    load_val    = '0;
    load_cnt    = '0;
    if (!stall_in) begin
      err_d = (accept & eop_token & eop_data)
            | (data_valid & (state_q == CRC))
            | (~data_valid & (eop_token | eop_data));
      case (state_q)
        IDLE, PAYLOAD: begin
          if (state_q == IDLE) begin
            out_bit_d = IDLE_LEVEL;
            out_sel_d = SEL_IDLE;
          end
          if (accept) begin
            out_bit_d   = data_bit;
            out_valid_d = 1'b1;
            out_sel_d   = SEL_PAYLOAD;
            state_d     = PAYLOAD;
            // data EOP takes priority when both markers arrive together
            if (eop_data) begin
              load      = 1'b1;
              load_val  = crc16_in;
              load_cnt  = CW'(CRC16_W - 1);
              crc_sel_d = SEL_CRC16;
              state_d   = CRC;
            end else if (eop_token) begin
              load                  = 1'b1;
              load_val[CRC5_W-1:0]  = crc5_in;
              load_cnt              = CW'(CRC5_W - 1);
              crc_sel_d             = SEL_CRC5;
              state_d               = CRC;
            end
          end
        end
        CRC: begin
          shift       = 1'b1;
          out_bit_d   = crc_bit;
          out_valid_d = 1'b1;
          out_sel_d   = crc_sel_q;
          if (last_bit) begin
            crc_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_bit   <= IDLE_LEVEL;
      out_valid <= 1'b0;
      out_sel   <= SEL_IDLE;
      crc_sel_q <= SEL_IDLE;
      crc_done  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_bit   <= out_bit_d;
      out_valid <= out_valid_d;
      out_sel   <= out_sel_d;
      crc_sel_q <= crc_sel_d;
      crc_done  <= crc_done_d;
      err_pulse <= err_d;
    end
  end

endmodule

// File: doc/crc_append_mux.md
Name: crc_append_mux

Overview:
Parametrised successor to the transmit-path payload/CRC mux in the Serial Interface Engine. It passes the serial payload stream through to the bit stuffer, then, on an end-of-payload marker, captures the matching parallel CRC (CRC5 for token packets, CRC16 for data packets) and shifts it out bit by bit. The block stalls cleanly when the bit stuffer inserts a stuffed bit, and drives a ready/valid handshake towards the payload serialiser.

Parameters:
CRC5_W, 5, width of the token CRC field
CRC16_W, 16, width of the data CRC field
MSB_FIRST, 1, 1 = CRC transmitted MSB first; 0 = LSB first
IDLE_LEVEL, 1'b1, value driven on out_bit when no packet is active

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
stall_in  in  1  bit stuffer busy inserting a stuffed bit; freeze all state
data_bit  in  1  payload bit from the serialiser
data_valid  in  1  data_bit is valid this cycle
data_ready  out  1  combinational: ~stall_in & (state != CRC)
eop_token  in  1  last payload bit of a token packet; qualified with data_valid
eop_data  in  1  last payload bit of a data packet; qualified with data_valid
crc5_in  in  CRC5_W  final (already complemented) token CRC; valid with eop_token
crc16_in  in  CRC16_W  final (already complemented) data CRC; valid with eop_data
out_bit  out  1  registered bit to the bit stuffer
out_valid  out  1  registered; out_bit is new this cycle
out_sel  out  2  registered source: 0 idle, 1 payload, 2 crc5, 3 crc16
crc_done  out  1  one-cycle pulse, registered with the last CRC bit
err_pulse  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, out_bit=IDLE_LEVEL, out_valid=0, out_sel=0, crc_done=0, err_pulse=0, shift register=0, count=0. Applies in any state, including mid-CRC; no partial CRC completes.
- Accepted beat: data_valid & data_ready at a rising edge.
- Latency: one clock from an accepted beat or CRC shift to out_bit/out_valid.
- State IDLE: out_bit=IDLE_LEVEL, out_valid=0. An accepted beat drives out_bit=data_bit, out_valid=1, out_sel=1, and moves the FSM to PAYLOAD. If that beat also carries an EOP, follow the EOP rule below.
- State PAYLOAD: each accepted beat gives out_bit=data_bit, out_valid=1. A cycle with no accepted beat gives out_valid=0 and holds out_bit.
- EOP rule: on an accepted beat with eop_token=1, load crc5_in, set count=CRC5_W-1, set out_sel=2 (registered with the first CRC bit), and move to CRC. eop_data works the same way with crc16_in, CRC16_W-1 and out_sel=3.
- Both EOPs asserted together: eop_data wins and err_pulse=1 for that cycle.
- State CRC: each cycle with stall_in=0 drives out_bit = register[count] (MSB_FIRST=1) or register[(W-1)-count] (MSB_FIRST=0), sets out_valid=1, and decrements count.
- CRC end: when count==0 is shifted, crc_done=1 on the same registered output and the FSM returns to IDLE. out_sel=0 from the next cycle.
- CRC inputs are sampled only at the EOP edge; later changes to crc5_in or crc16_in are ignored.
- data_ready=0 throughout CRC. data_valid=1 during CRC gives err_pulse=1 each such cycle; the data is dropped and the state is unaffected.
- EOP with data_valid=0: ignored, and err_pulse=1.
- stall_in=1 in any state: no state, count or register change; out_valid=0; out_bit and out_sel hold; data_ready=0.
- Back-to-back packets: a beat accepted in the cycle right after crc_done is legal (IDLE handles it), so the idle gap is zero.
- count width is clog2(CRC16_W); it never wraps because the exit is at 0.

Decomposition:
- Shared package sie_tx_pkg holds:
  - FSM state enum {IDLE, PAYLOAD, CRC}
  - out_sel encodings (SEL_IDLE, SEL_PAYLOAD, SEL_CRC5, SEL_CRC16)
  - default CRC5_W and CRC16_W constants
- One sub-module, crc_shift_reg: width CRC16_W, with a load of zero-extended CRC5/CRC16, a down-counter, a stall hold and a MSB_FIRST bit select, plus a last_bit flag.

Test Plan:
- Token packet, MSB_FIRST=1: 11 accepted payload bits, then eop_token with crc5_in=5'b10111 -> payload echoed one cycle late with out_sel=1; then out_bit 1,0,1,1,1 with out_sel=2; crc_done on the 5th CRC bit; IDLE_LEVEL afterwards.
- Data packet: eop_data with crc16_in=16'hA5C3 -> 16 CRC bits 1010_0101_1100_0011 with out_sel=3; with MSB_FIRST=0 the order is 1100_0011_1010_0101.
- Stall: stall_in=1 for 2 cycles after the 2nd CRC5 bit -> out_valid=0 and data_ready=0 for those cycles; the remaining 3 bits resume unchanged; crc_done is delayed by exactly 2 cycles.
- Reset mid-CRC16 after 7 bits -> the next cycle shows out_valid=0, out_sel=0, crc_done never pulses; a new token packet afterwards completes normally.
- Errors:
  - eop_token and eop_data together -> CRC16 path taken, err_pulse=1 for one cycle.
  - data_valid=1 during CRC -> data_ready=0, err_pulse=1, CRC sequence intact.
- Back-to-back: a new payload beat in the cycle after crc_done -> out_sel returns to 1 with no idle bit in between.
